// File: rtl/if_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_sequencer
//  Purpose  : Owns the single instruction-memory port. After reset it accepts
//             a program word stream from the loader and writes it into memory.
//             It then fetches instructions from RESET_PC onward for the IF/ID
//             register, handling stalls, branch redirects and a halt at the
//             end of memory.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W    instruction-memory word-address width (DEPTH = 2**ADDR_W),
//              at most 29 so that an out-of-range pc can be represented
//    RESET_PC  byte address fetched first after the program load completes
//  Ports
//    clock, resetn                 clock (rising edge), async active-low reset
//    reload                        1-cycle pulse: restart the program load
//    loadValid/loadReady/loadData/loadLast
//                                  loader word stream handshake
//    memWe/memAddr/memWdata/memRdata
//                                  instruction-memory port (1-cycle read)
//    stall, branchTaken, toPC      decode-side fetch control
//    pc, incrPC                    fetch address presented this cycle, pc + 4
//    fullInstruction/instPC/instValid
//                                  fetched instruction toward IF/ID
//    programLoaded, loadError      load done / more than DEPTH words offered
// ============================================================================
module if_fetch_sequencer #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              reload,
    input  logic              loadValid,
    output logic              loadReady,
    input  logic [31:0]       loadData,
    input  logic              loadLast,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    input  logic [31:0]       memRdata,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [31:0]       toPC,
    output logic [31:0]       pc,
    output logic [31:0]       incrPC,
    output logic [31:0]       fullInstruction,
    output logic [31:0]       instPC,
    output logic              instValid,
    output logic              programLoaded,
    output logic              loadError
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // One extra bit so the load address can saturate at DEPTH.
    logic [ADDR_W:0]   r_load_addr;
    logic [ADDR_W:0]   w_load_addr_nxt;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_nxt;
    logic [31:0]       r_inst_pc;
    logic [31:0]       w_inst_pc_nxt;
    logic [31:0]       r_inst_hold;
    logic [31:0]       w_inst_hold_nxt;
    logic              r_inst_valid;
    logic              w_inst_valid_nxt;
    logic              r_live;
    logic              w_live_nxt;
    logic              r_prog_loaded;
    logic              w_prog_loaded_nxt;
    logic              r_load_error;
    logic              w_load_error_nxt;

    logic [31:0]       w_incr_pc;
    logic [31:0]       w_branch_pc;
    logic              w_incr_oob;
    logic              w_branch_oob;
    logic              w_load_full;
    logic [31:0]       w_full_inst;

    assign w_incr_pc    = r_pc + 32'd4;
    // Fetch is word aligned: the byte offset of a redirect target is dropped.
    assign w_branch_pc  = toPC & 32'hFFFF_FFFC;
    assign w_incr_oob   = |w_incr_pc[31:ADDR_W+2];
    assign w_branch_oob = |w_branch_pc[31:ADDR_W+2];
    assign w_load_full  = r_load_addr[ADDR_W];

    // r_live marks that the previous cycle issued a read whose data is on
    // memRdata now. Otherwise the last shown instruction is replayed from
    // r_inst_hold, which keeps the output frozen across stalls even though
    // memory keeps re-reading the stalled pc.
    assign w_full_inst  = r_live ? memRdata : r_inst_hold;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_LOAD;
            r_load_addr   <= '0;
            r_pc          <= RESET_PC;
            r_inst_pc     <= 32'd0;
            r_inst_hold   <= 32'd0;
            r_inst_valid  <= 1'b0;
            r_live        <= 1'b0;
            r_prog_loaded <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_load_addr   <= w_load_addr_nxt;
            r_pc          <= w_pc_nxt;
            r_inst_pc     <= w_inst_pc_nxt;
            r_inst_hold   <= w_inst_hold_nxt;
            r_inst_valid  <= w_inst_valid_nxt;
            r_live        <= w_live_nxt;
            r_prog_loaded <= w_prog_loaded_nxt;
            r_load_error  <= w_load_error_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and memory-port control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_load_addr_nxt   = r_load_addr;
        w_pc_nxt          = r_pc;
        w_inst_pc_nxt     = r_inst_pc;
        w_inst_hold_nxt   = w_full_inst;
        w_inst_valid_nxt  = r_inst_valid;
        w_live_nxt        = 1'b0;
        w_prog_loaded_nxt = r_prog_loaded;
        w_load_error_nxt  = r_load_error;
        loadReady         = 1'b0;
        memWe             = 1'b0;
        memAddr           = r_pc[ADDR_W+1:2];
        memWdata          = loadData;

        if (reload) begin
            // Reload wins over everything else; the loader is refused this
            // cycle so no word is written into the program being restarted.
            w_state_nxt       = S_LOAD;
            w_load_addr_nxt   = '0;
            w_pc_nxt          = RESET_PC;
            w_inst_pc_nxt     = 32'd0;
            w_inst_hold_nxt   = 32'd0;
            w_inst_valid_nxt  = 1'b0;
            w_prog_loaded_nxt = 1'b0;
            w_load_error_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    loadReady        = 1'b1;
                    memAddr          = r_load_addr[ADDR_W-1:0];
                    w_inst_valid_nxt = 1'b0;
                    if (loadValid) begin
                        if (w_load_full) begin
                            // Memory is full: swallow the word, flag it.
                            w_load_error_nxt = 1'b1;
                        end else begin
                            memWe           = 1'b1;
                            w_load_addr_nxt = r_load_addr + (ADDR_W+1)'(1);
                        end
                        if (loadLast) begin
                            w_state_nxt       = S_RUN;
                            w_prog_loaded_nxt = 1'b1;
                            w_pc_nxt          = RESET_PC;
                        end
                    end
                end

                S_RUN: begin
                    if (branchTaken) begin
                        // The read issued this cycle is squashed.
                        w_inst_valid_nxt = 1'b0;
                        if (w_branch_oob) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pc_nxt = w_branch_pc;
                        end
                    end else if (!stall) begin
                        w_live_nxt       = 1'b1;
                        w_inst_valid_nxt = 1'b1;
                        w_inst_pc_nxt    = r_pc;
                        // The read at pc still issues; pc then parks on the
                        // last in-range address instead of wrapping.
                        if (w_incr_oob) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pc_nxt = w_incr_pc;
                        end
                    end
                end

                S_HALT: begin
                    w_inst_valid_nxt = 1'b0;
                end

                default: begin
                    w_state_nxt = S_LOAD;
                end
            endcase
        end
    end

    assign pc              = r_pc;
    assign incrPC          = w_incr_pc;
    assign fullInstruction = w_full_inst;
    assign instPC          = r_inst_pc;
    assign instValid       = r_inst_valid;
    assign programLoaded   = r_prog_loaded;
    assign loadError       = r_load_error;

endmodule
`default_nettype wire

// File: doc/if_fetch_sequencer.md
Name: if_fetch_sequencer

Overview:
- Sequences the instruction-fetch datapath: owns the single instruction-memory port and shares it between the program loader (writes) and the fetch stage (reads).
- After reset it accepts a program word stream, writes it into instruction memory and raises programLoaded.
- It then fetches from PC 0, handling stalls, branch redirects and end-of-memory halt.
- Sits between the program-load source, the instruction memory and the IF/ID pipeline register.

Parameters:
ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words
RESET_PC, 32'h0000_0000, byte address fetched first after load completes

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
reload  in  1  single-cycle pulse; restart program load from any state
loadValid  in  1  loader word valid
loadReady  out  1  sequencer accepts loader word
loadData  in  32  program word
loadLast  in  1  marks final program word (qualified by loadValid)
memWe  out  1  instruction-memory write enable
memAddr  out  ADDR_W  instruction-memory word address
memWdata  out  32  instruction-memory write data
memRdata  in  32  instruction-memory read data, synchronous, 1-cycle latency
stall  in  1  hazard stall from decode; hold fetch
branchTaken  in  1  redirect fetch this cycle
toPC  in  32  redirect target byte address
pc  out  32  byte address currently presented to memory
incrPC  out  32  pc + 4
fullInstruction  out  32  fetched instruction
instPC  out  32  byte address of fullInstruction
instValid  out  1  fullInstruction valid for decode
programLoaded  out  1  program load complete
loadError  out  1  sticky: more than DEPTH words offered

Behaviour:
- Reset (async, resetn=0): state LOAD; loadAddr=0; pc=RESET_PC; instPC=0; fullInstruction=0; instValid=0; programLoaded=0; loadError=0; memWe=0.
- States: LOAD, RUN, HALT.
- LOAD:
  - loadReady=1.
  - Handshake fires when loadValid&loadReady: memWe=loadValid combinationally, memAddr=loadAddr, memWdata=loadData; loadAddr increments.
  - When loadAddr == DEPTH (saturated), a word is still accepted but not written (memWe=0) and loadError is set.
  - Handshake with loadLast=1: next cycle state RUN, programLoaded=1, pc=RESET_PC.
  - instValid=0 throughout.
- RUN:
  - loadReady=0; memWe=0; memAddr=pc[ADDR_W+1:2].
  - Fetch latency 1 cycle: the instruction at pc appears on fullInstruction with instPC=that pc and instValid=1 on the following cycle.
  - pc advances by 4 each cycle when stall=0. incrPC = pc+4, 32-bit wrap.
  - On the first RUN cycle instValid=0, because no read is yet in flight.
  - stall=1 (no branch): pc, fullInstruction, instPC and instValid all hold. memAddr stays on pc; the re-read result is discarded.
  - branchTaken=1: pc<=toPC next cycle; the in-flight read is squashed (instValid=0 next cycle). Branch overrides stall.
  - toPC[1:0] is ignored (word-aligned fetch).
  - If the next pc word address would be >= DEPTH, i.e. pc[31:ADDR_W+2] != 0 after increment or redirect: the last valid instruction still issues, then state HALT.
- HALT:
  - instValid=0; pc holds; programLoaded stays 1.
  - Only reload or reset leaves HALT.
- reload pulse, any state: next cycle state LOAD; loadAddr=0; programLoaded=0; loadError=0; instValid=0; pc=RESET_PC.
  - A loader handshake in the same cycle as reload is not accepted (loadReady=0 that cycle).
- Reset asserted mid-load or mid-run: everything returns to reset values immediately. Memory contents are not cleared.
- Simultaneous events, priority: reset > reload > branchTaken > stall > normal advance.

Test Plan:
- Load 4 words (0x20080005, 0x20090003, 0x01095020, 0xAC0A0000; last on word 3) -> memWe pulses at addr 0..3; programLoaded=1 the cycle after the last handshake; pc=0.
- Free run after load -> instValid rises one cycle after RUN entry; instPC/fullInstruction sequence is 0/0x20080005, 4/0x20090003, 8/0x01095020; incrPC=pc+4.
- stall held 3 cycles at pc=8 -> pc, fullInstruction and instValid frozen; resumes at pc=12 with no lost or duplicated instruction.
- branchTaken with toPC=0x4 while pc=0xC, together with stall=1 -> next cycle pc=4, instValid=0; the following cycle instPC=4.
- ADDR_W=2: load 5 words -> loadError=1, only addresses 0..3 written. Run -> after instPC=0xC issues, state HALT and instValid stays 0.
- resetn pulsed low after 2 load words, then reload mid-RUN -> outputs return to reset values asynchronously; reload clears programLoaded and restarts at loadAddr 0.
